// File: rtl/multimode_counter.sv
// Parametrised sequence counter: one internal index presented as binary, Gray,
// Johnson or one-hot ring, with direction, enable, synchronous load and wrap pulse.
module multimode_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_idx,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_BIN  = 2'b00,
    MODE_GRAY = 2'b01,
    MODE_JOHN = 2'b10,
    MODE_RING = 2'b11
  } mode_e;

  localparam int unsigned JOHN_LAST = 2 * WIDTH - 1;
  localparam int unsigned RING_LAST = WIDTH - 1;

  // Last legal index (period - 1) of the sequence for a given mode.
  function automatic logic [WIDTH-1:0] last_idx(input mode_e m);
    logic [WIDTH-1:0] v;
    v = '1;
    case (m)
      MODE_BIN:  v = '1;
      MODE_GRAY: v = '1;
      MODE_JOHN: v = WIDTH'(JOHN_LAST);
      MODE_RING: v = WIDTH'(RING_LAST);
      default:   v = '1;
    endcase
    return v;
  endfunction

  // Presentation of index k in mode m.
  function automatic logic [WIDTH-1:0] encode(input mode_e m, input logic [WIDTH-1:0] k);
    logic [WIDTH-1:0] v;
    v = '0;
    case (m)
      MODE_BIN:  v = k;
      MODE_GRAY: v = k ^ (k >> 1);
      MODE_JOHN: begin
        // Filling phase sets the low k bits; draining phase keeps bits above k-WIDTH.
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (k <= WIDTH'(WIDTH)) v[i] = (WIDTH'(i) < k);
          else                    v[i] = (WIDTH'(i) >= (k - WIDTH'(WIDTH)));
        end
      end
      MODE_RING: v = WIDTH'(1) << k;
      default:   v = '0;
    endcase
    return v;
  endfunction

  mode_e            mode_in;
  mode_e            mode_q;
  mode_e            mode_d;
  logic [WIDTH-1:0] idx_q;
  logic [WIDTH-1:0] idx_d;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] last_in;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;

  assign mode_in = mode_e'(mode);
  assign last_q  = last_idx(mode_q);
  assign last_in = last_idx(mode_in);

  // State register; count is registered as the decode of the next index/mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      mode_q  <= MODE_BIN;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next index by priority: load, mode change, step up, step down, hold.
  always_comb begin
    idx_d   = idx_q;
    mode_d  = mode_in;
    wrap_d  = 1'b0;
    if (load) begin
      idx_d = (load_idx <= last_in) ? load_idx : '0;
    end else if (mode_in != mode_q) begin
      idx_d = '0;
    end else if (en) begin
      if (dir) begin
        wrap_d = (idx_q == last_q);
        idx_d  = (idx_q == last_q) ? '0 : idx_q + WIDTH'(1);
      end else begin
        wrap_d = (idx_q == '0);
        idx_d  = (idx_q == '0) ? last_q : idx_q - WIDTH'(1);
      end
    end
    count_d = encode(mode_d, idx_d);
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_multimode_counter.sv
// Bench for multimode_counter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an arithmetic sequence model.
module tb_multimode_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         dir;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_idx;
  logic [W-1:0] count;
  logic         wrap;

  int total = 0;
  int bad   = 0;

  multimode_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode),
    .load(load), .load_idx(load_idx), .count(count), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int period(input int md);
    case (md)
      0, 1:    return 1 << W;
      2:       return 2 * W;
      default: return W;
    endcase
  endfunction

  function automatic int expect_enc(input int md, input int k);
    case (md)
      0: return k;
      1: return k ^ (k >> 1);
      2: return (k <= W) ? ((1 << k) - 1) : (((1 << W) - 1) & ~((1 << (k - W)) - 1));
      default: return 1 << k;
    endcase
  endfunction

  // Reference state: sequence position, active mode, wrap flag.
  int m_idx  = 0;
  int m_mode = 0;
  bit m_wrap = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx = 0; m_mode = 0; m_wrap = 1'b0;
    end else begin
      int p;
      p = period(int'(mode));
      if (load) begin
        m_idx  = (int'(load_idx) < p) ? int'(load_idx) : 0;
        m_wrap = 1'b0;
      end else if (int'(mode) != m_mode) begin
        m_idx  = 0;
        m_wrap = 1'b0;
      end else if (en) begin
        if (dir) begin
          m_wrap = (m_idx == p - 1);
          m_idx  = (m_idx + 1) % p;
        end else begin
          m_wrap = (m_idx == 0);
          m_idx  = (m_idx + p - 1) % p;
        end
      end else begin
        m_wrap = 1'b0;
      end
      m_mode = int'(mode);
    end
  end

  always @(negedge clk) begin
    total++;
    if (int'(count) != expect_enc(m_mode, m_idx) || wrap != m_wrap) begin
      bad++;
      $display("FAIL model t=%0t count=%b wrap=%b required count=%b wrap=%b",
               $time, count, wrap, W'(expect_enc(m_mode, m_idx)), m_wrap);
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // Drive one cycle of inputs (from the falling edge) and check the result literally.
  task automatic cyc(input string name, input bit e, input bit d, input int md,
                     input bit ld, input int li, input int ec, input bit ew);
    en = e; dir = d; mode = 2'(md); load = ld; load_idx = W'(li);
    @(posedge clk);
    @(negedge clk);
    check({name, "_count"}, int'(count), ec);
    check({name, "_wrap"}, int'(wrap), int'(ew));
  endtask

  int jseq [9] = '{0, 1, 3, 7, 15, 14, 12, 8, 0};
  int cur_mode;

  initial begin
    rst_n = 1'b1; en = 1'b1; dir = 1'b1; mode = 2'b00; load = 1'b0; load_idx = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_wrap", int'(wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) cyc("bin", 1, 1, 0, 0, 0, i % 16, i == 16);
    for (int i = 1; i <= 5; i++)  cyc("bin5", 1, 1, 0, 0, 0, i, 1'b0);

    cyc("gray_switch", 1, 1, 1, 0, 0, 0, 1'b0);
    for (int i = 1; i <= 16; i++) cyc("gray", 1, 1, 1, 0, 0, (i % 16) ^ ((i % 16) >> 1), i == 16);

    for (int i = 0; i < 9; i++) cyc("john_up", 1, 1, 2, 0, 0, jseq[i], i == 8);
    cyc("john_down", 1, 0, 2, 0, 0, 8, 1'b1);

    cyc("ring_switch", 1, 0, 3, 0, 0, 1, 1'b0);
    cyc("ring_wrap",   1, 0, 3, 0, 0, 8, 1'b1);
    cyc("ring_hold1",  0, 0, 3, 0, 0, 8, 1'b0);
    cyc("ring_step1",  1, 0, 3, 0, 0, 4, 1'b0);
    cyc("ring_hold2",  0, 0, 3, 0, 0, 4, 1'b0);
    cyc("ring_step2",  1, 0, 3, 0, 0, 2, 1'b0);

    cyc("load5",       0, 1, 2, 1, 5, 14, 1'b0);
    cyc("load9",       0, 1, 2, 1, 9, 0, 1'b0);
    cyc("load7",       0, 1, 2, 1, 7, 8, 1'b0);
    cyc("load_vs_en",  1, 1, 2, 1, 2, 3, 1'b0);
    cyc("load_mode",   0, 1, 3, 1, 3, 8, 1'b0);

    cyc("ar_switch", 0, 1, 1, 0, 0, 0, 1'b0);
    cyc("ar_g1", 1, 1, 1, 0, 0, 1, 1'b0);
    cyc("ar_g2", 1, 1, 1, 0, 0, 3, 1'b0);
    cyc("ar_g3", 1, 1, 1, 0, 0, 2, 1'b0);
    cyc("ar_g4", 1, 1, 1, 0, 0, 6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_count", int'(count), 0);
    check("async_wrap", int'(wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst1", 1, 1, 1, 0, 0, 0, 1'b0);
    cyc("post_rst2", 1, 1, 1, 0, 0, 1, 1'b0);

    // Randomized traffic; the per-cycle model comparison does the checking.
    cur_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) cur_mode = int'($urandom_range(0, 3));
      en       = ($urandom_range(0, 3) != 0);
      dir      = ($urandom_range(0, 1) != 0);
      mode     = 2'(cur_mode);
      load     = ($urandom_range(0, 15) == 0);
      load_idx = W'($urandom_range(0, (1 << W) - 1));
      @(posedge clk);
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multimode_counter.md
Name: multimode_counter

Overview:
- Parametrised successor to the lab's fixed 3-bit binary/Gray counter.
- A single internal sequence index can be presented in one of four encodings: binary, Gray, Johnson or one-hot ring.
- Adds count direction, count enable, synchronous load and a registered wrap flag.
- Used as a generic sequencer/counter primitive in later lab exercises.

Parameters:
- WIDTH, 4, width of Count and of the internal index; legal range 2..16.

Ports:
- Clk      input   1      rising-edge clock
- nReset   input   1      asynchronous active-low reset
- En       input   1      count enable; index steps once per edge while high
- Dir      input   1      1 = up (index+1), 0 = down (index-1)
- Mode     input   2      00 binary, 01 Gray, 10 Johnson, 11 one-hot ring
- Load     input   1      synchronous load of LoadIdx into the index
- LoadIdx  input   WIDTH  sequence index to load
- Count    output  WIDTH  encoded value of the current index in the registered mode
- Wrap     output  1      one-cycle registered pulse after a wrap-around step

Behaviour:
- State registers:
  - Idx[WIDTH-1:0]: sequence position.
  - ModeQ[1:0]: active mode.
  - Wrap: registered flag.
- Sequence period P depends on ModeQ:
  - binary: 2^WIDTH
  - Gray: 2^WIDTH
  - Johnson: 2*WIDTH
  - ring: WIDTH
- Idx is always in 0..P-1. This always fits in WIDTH bits, since 2*WIDTH <= 2^WIDTH for WIDTH >= 2.
- Count is a combinational decode of registered Idx and ModeQ only; no input reaches Count combinationally.
  - binary: Count = Idx
  - Gray: Count = Idx ^ (Idx >> 1)
  - Johnson: for k = Idx <= WIDTH, the low k bits are 1 and the rest 0. For k > WIDTH, the top (2*WIDTH - k) bits are 1 and the rest 0. WIDTH=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - ring: Count = 1 << Idx
- Reset (nReset low, asynchronous, takes effect immediately and holds while low):
  - Idx = 0, ModeQ = 00, Wrap = 0, therefore Count = 0.
  - A reset mid-sequence abandons the count.
  - The first edge after release evaluates the priorities below normally.
- Each rising edge (nReset high): ModeQ <= Mode always. Idx is updated by priority:
  1. Load = 1: Idx <= LoadIdx if LoadIdx < P(Mode), where P is evaluated for the new Mode. Otherwise Idx <= 0. Wrap <= 0.
  2. Mode != ModeQ: Idx <= 0; the new sequence restarts at its first element. Wrap <= 0. En is ignored this cycle.
  3. En = 1, Dir = 1: Idx <= (Idx == P-1) ? 0 : Idx+1. Wrap <= (Idx == P-1).
  4. En = 1, Dir = 0: Idx <= (Idx == 0) ? P-1 : Idx-1. Wrap <= (Idx == 0).
  5. Otherwise: Idx holds, Wrap <= 0.
- Latency:
  - Count and Wrap change one edge after the causing inputs.
  - Wrap is high for exactly one cycle per wrap step.
  - With En held high, consecutive wraps give one pulse every P cycles.
- Dir may change on any cycle; the step on that edge uses the new Dir. No extra state.
- Changing mode gives no carry-over of position, per priority 2.
- All arithmetic is modulo P, never modulo 2^WIDTH, for Johnson and ring.

Test Plan (WIDTH=4, 10 ns clock):
- Reset, then binary count: nReset=0 for 2 cycles, Mode=00, Dir=1, En=1, release. Expected: Count=0 during reset, then 1, 2 ... 15, 0. Wrap high exactly in the cycle Count first shows 0 after 15, and never on any other cycle.
- Gray mid-run mode switch: run binary to Count=5, then set Mode=01. Expected: next Count=0000, then 0001, 0011, 0010, 0110 ... 1000, 0000 over 16 steps, with one Wrap pulse. No Wrap on the switch cycle.
- Johnson up then down: Mode=10, Dir=1, 9 steps. Expected: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, with Wrap on the last step. Then Dir=0 for 1 step. Expected: Count=1000 (Idx=7) and Wrap high.
- Ring down with enable gaps: Mode=11, Dir=0, toggle En 1/0 each cycle. Expected: Count 0001 -> 1000 (Wrap) -> hold -> 0100 -> hold -> 0010. No Wrap on hold cycles.
- Load rules:
  - Mode=10, LoadIdx=5. Expected: Count=1110.
  - LoadIdx=9 (>= P=8). Expected: Count=0000.
  - Load=1 and En=1 in the same cycle with Idx=P-1. Expected: load wins, Wrap stays 0.
  - Load with Mode changing to 11 and LoadIdx=3. Expected: Count=1000.
- Asynchronous reset mid-operation: assert nReset low mid-cycle in Gray mode at Count=0110. Expected: Count=0 and Wrap=0 immediately, without waiting for Clk. After release with Mode=01, the first edge restarts at 0 because ModeQ=00 differs from Mode. The second edge gives Count=0001.
